// File: rtl/toy_pack.sv
// Shared toy-bus definitions used by the LSU request ports.
package toy_pack;

  localparam int unsigned TOY_BUS_OP_WIDTH = 2;

  typedef enum logic [TOY_BUS_OP_WIDTH-1:0] {
    TOY_BUS_READ  = 2'd0,
    TOY_BUS_WRITE = 2'd1,
    TOY_BUS_FENCE = 2'd2
  } toy_bus_op_e;

endpackage

// File: rtl/toy_lsu_stq.sv
// LSU store queue: in-order circular buffer of resolved stores, committed at retire
// and drained to memory in order; all entries are exported for load hazard search.
module toy_lsu_stq #(
  parameter int unsigned STU_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned SB_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      s_st_vld,
  output logic                                      s_st_rdy,
  input  logic [ADDR_WIDTH-1:0]                     s_st_addr,
  input  logic [DATA_WIDTH-1:0]                     s_st_data,
  input  logic [STRB_WIDTH-1:0]                     s_st_strb,
  input  logic [SB_WIDTH-1:0]                       s_st_sideband,
  input  logic                                      commit_en,
  input  logic                                      cancel_en,
  output logic [STU_DEPTH-1:0]                      v_stq_en,
  output logic [STU_DEPTH*ADDR_WIDTH-1:0]           v_stq_addr,
  output logic [STU_DEPTH*DATA_WIDTH-1:0]           v_stq_data,
  output logic [STU_DEPTH*STRB_WIDTH-1:0]           v_stq_strb,
  output logic [$clog2(STU_DEPTH)-1:0]              stq_wr_ptr,
  output logic                                      stq_full,
  output logic                                      stq_empty,
  output logic                                      m_mem_req_vld,
  input  logic                                      m_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]                     m_mem_req_addr,
  output logic [DATA_WIDTH-1:0]                     m_mem_req_data,
  output logic [STRB_WIDTH-1:0]                     m_mem_req_strb,
  output logic [SB_WIDTH-1:0]                       m_mem_req_sideband,
  output logic [toy_pack::TOY_BUS_OP_WIDTH-1:0]     m_mem_req_opcode
);

  localparam int unsigned PW = $clog2(STU_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         ncmt_q, ncmt_d;
  logic [STU_DEPTH-1:0]  valid_q, valid_d;
  logic [STU_DEPTH-1:0]  cmtd_q, cmtd_d;

  logic [ADDR_WIDTH-1:0] addr_q [STU_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [STU_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [STU_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [STU_DEPTH];
  logic [STRB_WIDTH-1:0] strb_q [STU_DEPTH];
  logic [STRB_WIDTH-1:0] strb_d [STU_DEPTH];
  logic [SB_WIDTH-1:0]   sb_q   [STU_DEPTH];
  logic [SB_WIDTH-1:0]   sb_d   [STU_DEPTH];

  logic                  full;
  logic                  enq_fire;
  logic                  cmt_fire;
  logic                  drn_fire;
  logic [CW-1:0]         uncmt_cnt;

  // Status derived from registered state only, so rdy never sees a same-cycle drain.
  assign full      = (count_q == CW'(STU_DEPTH));
  assign uncmt_cnt = count_q - ncmt_q;
  assign enq_fire  = s_st_vld & ~full & ~cancel_en;
  assign cmt_fire  = commit_en & (uncmt_cnt != '0);
  assign drn_fire  = m_mem_req_vld & m_mem_req_rdy;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ncmt_d    = ncmt_q;
    valid_d   = valid_q;
    cmtd_d    = cmtd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    sb_d      = sb_q;

    if (cmt_fire) begin
      cmtd_d[cmt_ptr_q] = 1'b1;
      cmt_ptr_d         = cmt_ptr_q + PW'(1);
    end

    if (drn_fire) begin
      valid_d[rd_ptr_q] = 1'b0;
      cmtd_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end

    ncmt_d = ncmt_q + CW'(cmt_fire) - CW'(drn_fire);

    // Flush sees this cycle's commit, so a just-committed entry survives.
    if (cancel_en) begin
      for (int i = 0; i < STU_DEPTH; i++) begin
        if (!cmtd_d[i]) begin
          valid_d[i] = 1'b0;
        end
      end
      wr_ptr_d = cmt_ptr_d;
      count_d  = ncmt_d;
    end else begin
      if (enq_fire) begin
        valid_d[wr_ptr_q] = 1'b1;
        cmtd_d[wr_ptr_q]  = 1'b0;
        addr_d[wr_ptr_q]  = s_st_addr;
        data_d[wr_ptr_q]  = s_st_data;
        strb_d[wr_ptr_q]  = s_st_strb;
        sb_d[wr_ptr_q]    = s_st_sideband;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq_fire) - CW'(drn_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ncmt_q    <= '0;
      valid_q   <= '0;
      cmtd_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ncmt_q    <= ncmt_d;
      valid_q   <= valid_d;
      cmtd_q    <= cmtd_d;
    end
  end

  // Payload storage is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
    sb_q   <= sb_d;
  end

  always_comb begin
    v_stq_addr = '0;
    v_stq_data = '0;
    v_stq_strb = '0;
    for (int i = 0; i < STU_DEPTH; i++) begin
      v_stq_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[i];
      v_stq_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
      v_stq_strb[i*STRB_WIDTH +: STRB_WIDTH] = strb_q[i];
    end
  end

  assign v_stq_en   = valid_q;
  assign stq_wr_ptr = wr_ptr_q;
  assign stq_full   = full;
  assign stq_empty  = (count_q == '0);
  assign s_st_rdy   = ~full;

  // Head entry is stable while waiting: only a handshake moves rd_ptr or clears it.
  assign m_mem_req_vld      = valid_q[rd_ptr_q] & cmtd_q[rd_ptr_q];
  assign m_mem_req_addr     = addr_q[rd_ptr_q];
  assign m_mem_req_data     = data_q[rd_ptr_q];
  assign m_mem_req_strb     = strb_q[rd_ptr_q];
  assign m_mem_req_sideband = sb_q[rd_ptr_q];
  assign m_mem_req_opcode   = toy_pack::TOY_BUS_WRITE;

endmodule

// File: tb/tb_toy_lsu_stq.sv
// Self-checking bench for toy_lsu_stq against a queue-based store-queue model.
module tb_toy_lsu_stq;

  localparam int unsigned D = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_st_vld;
  logic          s_st_rdy;
  logic [31:0]   s_st_addr;
  logic [31:0]   s_st_data;
  logic [3:0]    s_st_strb;
  logic [15:0]   s_st_sideband;
  logic          commit_en;
  logic          cancel_en;
  logic [7:0]    v_stq_en;
  logic [255:0]  v_stq_addr;
  logic [255:0]  v_stq_data;
  logic [31:0]   v_stq_strb;
  logic [2:0]    stq_wr_ptr;
  logic          stq_full;
  logic          stq_empty;
  logic          m_mem_req_vld;
  logic          m_mem_req_rdy;
  logic [31:0]   m_mem_req_addr;
  logic [31:0]   m_mem_req_data;
  logic [3:0]    m_mem_req_strb;
  logic [15:0]   m_mem_req_sideband;
  logic [1:0]    m_mem_req_opcode;

  toy_lsu_stq dut (
    .clk(clk), .rst_n(rst_n),
    .s_st_vld(s_st_vld), .s_st_rdy(s_st_rdy), .s_st_addr(s_st_addr),
    .s_st_data(s_st_data), .s_st_strb(s_st_strb), .s_st_sideband(s_st_sideband),
    .commit_en(commit_en), .cancel_en(cancel_en),
    .v_stq_en(v_stq_en), .v_stq_addr(v_stq_addr), .v_stq_data(v_stq_data),
    .v_stq_strb(v_stq_strb), .stq_wr_ptr(stq_wr_ptr), .stq_full(stq_full),
    .stq_empty(stq_empty), .m_mem_req_vld(m_mem_req_vld), .m_mem_req_rdy(m_mem_req_rdy),
    .m_mem_req_addr(m_mem_req_addr), .m_mem_req_data(m_mem_req_data),
    .m_mem_req_strb(m_mem_req_strb), .m_mem_req_sideband(m_mem_req_sideband),
    .m_mem_req_opcode(m_mem_req_opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] b;
  } ent_t;

  // Model: program-order list of live stores; the first m_ncm of them are committed.
  ent_t        mq[$];
  int          m_ncm;
  int          m_head;
  logic [31:0] exp_drain[$];
  logic [31:0] dut_drain[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] m_en();
    logic [7:0] e = '0;
    for (int k = 0; k < mq.size(); k++) e[(m_head + k) % D] = 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] m_wr();
    return 3'((m_head + mq.size()) % D);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_st_vld = 0; s_st_addr = 0; s_st_data = 0; s_st_strb = 0; s_st_sideband = 0;
    commit_en = 0; cancel_en = 0; m_mem_req_rdy = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete(); m_ncm = 0; m_head = 0;
  endtask

  // One clock: drive inputs, log a DUT handshake, then advance the model.
  task automatic cycle(input logic vld, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [15:0] b,
                       input logic cm, input logic cn, input logic rdy);
    int   sz;
    logic drn, enq, cf;
    ent_t e;
    s_st_vld = vld; s_st_addr = a; s_st_data = d; s_st_strb = s; s_st_sideband = b;
    commit_en = cm; cancel_en = cn; m_mem_req_rdy = rdy;
    #3;
    if (m_mem_req_vld && m_mem_req_rdy) dut_drain.push_back(m_mem_req_addr);
    sz  = mq.size();
    drn = (m_ncm > 0) && rdy;
    enq = vld && (sz < D) && !cn;
    cf  = cm && (m_ncm < sz);
    @(posedge clk);
    if (cf) m_ncm++;
    if (drn) begin
      exp_drain.push_back(mq[0].a);
      void'(mq.pop_front());
      m_head = (m_head + 1) % D;
      m_ncm--;
    end
    if (cn) begin
      while (mq.size() > m_ncm) void'(mq.pop_back());
    end else if (enq) begin
      e.a = a; e.d = d; e.s = s; e.b = b;
      mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic push(input logic [31:0] a);
    cycle(1, a, ~a, 4'hf, a[15:0], 0, 0, 0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0) break;
      cycle(0, 0, 0, 0, 0, 1, 0, 1);
    end
    checks++;
    if (stq_empty !== 1'b1) begin
      errors++; $display("FAIL drain_all_empty: got %b want 1", stq_empty);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stq_empty, stq_full, s_st_rdy, m_mem_req_vld} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags: empty/full/rdy/vld got %b want 1010",
                         {stq_empty, stq_full, s_st_rdy, m_mem_req_vld});
    end
    checks++;
    if (v_stq_en !== 8'h00 || stq_wr_ptr !== 3'd0) begin
      errors++; $display("FAIL reset_state: en %h wr %0d want 00 0", v_stq_en, stq_wr_ptr);
    end
  endtask

  task automatic test_enqueue_no_commit();
    int vld_seen = 0;
    push(32'h100); push(32'h104); push(32'h108);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (m_mem_req_vld !== 1'b0) vld_seen++;
    end
    checks++;
    if (v_stq_en !== 8'b0000_0111) begin
      errors++; $display("FAIL enq_en: got %b want 00000111", v_stq_en);
    end
    checks++;
    if (stq_wr_ptr !== 3'd3) begin
      errors++; $display("FAIL enq_wr_ptr: got %0d want 3", stq_wr_ptr);
    end
    checks++;
    if (vld_seen != 0) begin
      errors++; $display("FAIL enq_no_req: vld high %0d cycles want 0", vld_seen);
    end
    checks++;
    if (v_stq_addr[63:32] !== 32'h104 || v_stq_data[63:32] !== ~32'h104 || v_stq_strb[7:4] !== 4'hf) begin
      errors++; $display("FAIL enq_entry1: addr %h data %h strb %h", v_stq_addr[63:32],
                         v_stq_data[63:32], v_stq_strb[7:4]);
    end
  endtask

  task automatic test_commit_drain();
    int base = dut_drain.size();
    int bad_op = 0;
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (m_mem_req_vld === 1'b1 && m_mem_req_opcode !== toy_pack::TOY_BUS_WRITE) bad_op++;
      idle(1);
    end
    checks++;
    if (dut_drain.size() - base != 2) begin
      errors++; $display("FAIL cd_count: got %0d drains want 2", dut_drain.size() - base);
    end else begin
      checks++;
      if (dut_drain[base] !== 32'h100 || dut_drain[base+1] !== 32'h104) begin
        errors++; $display("FAIL cd_order: got %h %h want 100 104", dut_drain[base], dut_drain[base+1]);
      end
    end
    checks++;
    if (bad_op != 0) begin
      errors++; $display("FAIL cd_opcode: %0d bad opcodes", bad_op);
    end
    checks++;
    if (v_stq_en !== 8'b0000_0100) begin
      errors++; $display("FAIL cd_en: got %b want 00000100", v_stq_en);
    end
  endtask

  task automatic test_full();
    logic [2:0] wr_full;
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i));
    checks++;
    if (stq_full !== 1'b1 || s_st_rdy !== 1'b0 || v_stq_en !== 8'hff) begin
      errors++; $display("FAIL full_flags: full %b rdy %b en %h want 1 0 ff", stq_full, s_st_rdy, v_stq_en);
    end
    wr_full = stq_wr_ptr;
    push(32'h300);
    checks++;
    if (stq_wr_ptr !== wr_full || stq_wr_ptr !== m_wr()) begin
      errors++; $display("FAIL full_hold: wr %0d want %0d", stq_wr_ptr, m_wr());
    end
    cycle(1, 32'h304, 0, 4'h1, 0, 1, 0, 0);
    checks++;
    if (s_st_rdy !== 1'b0 || m_mem_req_vld !== 1'b1 || m_mem_req_addr !== 32'h108) begin
      errors++; $display("FAIL full_commit: rdy %b vld %b addr %h want 0 1 108",
                         s_st_rdy, m_mem_req_vld, m_mem_req_addr);
    end
    cycle(1, 32'h308, 0, 4'h1, 0, 0, 0, 1);
    checks++;
    if (s_st_rdy !== 1'b1 || stq_wr_ptr !== wr_full || stq_full !== 1'b0) begin
      errors++; $display("FAIL full_release: rdy %b wr %0d full %b want 1 %0d 0",
                         s_st_rdy, stq_wr_ptr, stq_full, wr_full);
    end
    drain_all();
  endtask

  task automatic test_cancel();
    int base;
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(4 * i));
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 32'h4ff, 0, 0, 0, 0, 1, 0);
    checks++;
    if (v_stq_en !== 8'b0000_0011 || stq_wr_ptr !== 3'd2 || m_mem_req_vld !== 1'b1) begin
      errors++; $display("FAIL cancel_state: en %b wr %0d vld %b want 00000011 2 1",
                         v_stq_en, stq_wr_ptr, m_mem_req_vld);
    end
    base = dut_drain.size();
    idle(1); idle(1);
    checks++;
    if (stq_empty !== 1'b1 || dut_drain.size() - base != 2) begin
      errors++; $display("FAIL cancel_drain: empty %b drains %0d want 1 2", stq_empty, dut_drain.size() - base);
    end
  endtask

  task automatic test_commit_cancel();
    do_reset();
    push(32'h500); push(32'h504); push(32'h508);
    cycle(1, 32'h50c, 0, 0, 0, 1, 1, 0);
    checks++;
    if (v_stq_en !== 8'b0000_0001 || stq_wr_ptr !== 3'd1) begin
      errors++; $display("FAIL cc_state: en %b wr %0d want 00000001 1", v_stq_en, stq_wr_ptr);
    end
    checks++;
    if (m_mem_req_vld !== 1'b1 || m_mem_req_addr !== 32'h500 || m_mem_req_sideband !== 16'h0500) begin
      errors++; $display("FAIL cc_head: vld %b addr %h sb %h want 1 500 0500",
                         m_mem_req_vld, m_mem_req_addr, m_mem_req_sideband);
    end
    idle(1);
    checks++;
    if (stq_empty !== 1'b1) begin
      errors++; $display("FAIL cc_empty: got %b want 1", stq_empty);
    end
  endtask

  task automatic test_wrap_random();
    logic [2:0]  prev_wr;
    logic        wrapped = 1'b0;
    logic [31:0] a;
    int          n = 0;
    do_reset();
    exp_drain.delete(); dut_drain.delete();
    prev_wr = stq_wr_ptr;
    for (int c = 0; c < 80; c++) begin
      a = 32'h1000 + 32'(4 * n);
      n++;
      cycle($urandom_range(0, 3) != 0, a, $urandom, 4'($urandom), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)));
      if (prev_wr == 3'd7 && stq_wr_ptr == 3'd0) wrapped = 1'b1;
      prev_wr = stq_wr_ptr;
      checks++;
      if (v_stq_en !== m_en() || stq_wr_ptr !== m_wr() || stq_full !== (mq.size() == D) ||
          stq_empty !== (mq.size() == 0) || s_st_rdy !== (mq.size() != D) ||
          m_mem_req_vld !== (m_ncm > 0)) begin
        errors++; $display("FAIL rnd_state c%0d: en %b/%b wr %0d/%0d full %b empty %b vld %b/%0d",
                           c, v_stq_en, m_en(), stq_wr_ptr, m_wr(), stq_full, stq_empty,
                           m_mem_req_vld, m_ncm);
      end
      if (m_ncm > 0) begin
        checks++;
        if (m_mem_req_addr !== mq[0].a || m_mem_req_data !== mq[0].d ||
            m_mem_req_strb !== mq[0].s || m_mem_req_sideband !== mq[0].b) begin
          errors++; $display("FAIL rnd_head c%0d: addr %h want %h data %h want %h",
                             c, m_mem_req_addr, mq[0].a, m_mem_req_data, mq[0].d);
        end
      end
      for (int k = 0; k < mq.size(); k++) begin
        int s = (m_head + k) % D;
        checks++;
        if (v_stq_addr[s*32 +: 32] !== mq[k].a || v_stq_data[s*32 +: 32] !== mq[k].d ||
            v_stq_strb[s*4 +: 4] !== mq[k].s) begin
          errors++; $display("FAIL rnd_entry c%0d slot %0d: addr %h want %h",
                             c, s, v_stq_addr[s*32 +: 32], mq[k].a);
        end
      end
    end
    drain_all();
    checks++;
    if (dut_drain.size() != exp_drain.size()) begin
      errors++; $display("FAIL rnd_drain_count: got %0d want %0d", dut_drain.size(), exp_drain.size());
    end else begin
      for (int i = 0; i < exp_drain.size(); i++) begin
        checks++;
        if (dut_drain[i] !== exp_drain[i]) begin
          errors++; $display("FAIL rnd_drain_order %0d: got %h want %h", i, dut_drain[i], exp_drain[i]);
        end
      end
    end
    checks++;
    if (wrapped !== 1'b1) begin
      errors++; $display("FAIL rnd_wrap: wr_ptr never wrapped 7->0");
    end
  endtask

  initial begin
    test_reset();
    test_enqueue_no_commit();
    test_commit_drain();
    test_full();
    test_cancel();
    test_commit_cancel();
    test_wrap_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
